// File: rtl/coeff_window_fetcher_pkg.sv
// rtl/coeff_window_fetcher_pkg.sv - shared constants, slot offsets and FSM encodings
// Contents:
//   SB_*           subband codes, shared with the bit-plane coder
//   fetch_state_e  fetch FSM state encodings
//   slot_drow/dcol row/column offset of window slot k (k=0..8, row-major)
package coeff_window_fetcher_pkg;

  localparam logic [2:0] SB_LL  = 3'd0;
  localparam logic [2:0] SB_HL1 = 3'd1;
  localparam logic [2:0] SB_HL2 = 3'd2;
  localparam logic [2:0] SB_LH1 = 3'd3;
  localparam logic [2:0] SB_LH2 = 3'd4;
  localparam logic [2:0] SB_HH1 = 3'd5;
  localparam logic [2:0] SB_HH2 = 3'd6;

  localparam logic [3:0] LAST_SLOT = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } fetch_state_e;

  // Row offset of slot k: top row for 0..2, centre row for 3..5, bottom row for 6..8.
  function automatic logic signed [1:0] slot_drow(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: slot_drow = 2'sb11;
      4'd3, 4'd4, 4'd5: slot_drow = 2'sb00;
      default:          slot_drow = 2'sb01;
    endcase
  endfunction

  // Column offset of slot k: left column for 0,3,6, centre for 1,4,7, right otherwise.
  function automatic logic signed [1:0] slot_dcol(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: slot_dcol = 2'sb11;
      4'd1, 4'd4, 4'd7: slot_dcol = 2'sb00;
      default:          slot_dcol = 2'sb01;
    endcase
  endfunction

endpackage

// File: rtl/coeff_window_fetcher_window_addr_gen.sv
// rtl/coeff_window_fetcher_window_addr_gen.sv - neighbour range check and RAM address for one window slot
// Ports:
//   r, c             centre coefficient row/column
//   k                window slot 0..8
//   width, height    subband dimensions
//   base_addr        RAM address of coefficient (0,0)
//   in_range         neighbour lies inside the subband
//   ram_addr         base_addr + row*width + col (meaningful only when in_range)
module window_addr_gen
  import coeff_window_fetcher_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 9
) (
  input  logic [DIM_W-1:0]  r,
  input  logic [DIM_W-1:0]  c,
  input  logic [3:0]        k,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              in_range,
  output logic [ADDR_W-1:0] ram_addr
);

  logic signed [1:0]    drow;
  logic signed [1:0]    dcol;
  // Two extra bits: bit DIM_W holds r+1 == 2**DIM_W-ish overflow, MSB flags a -1 result.
  logic [DIM_W+1:0]     row_x;
  logic [DIM_W+1:0]     col_x;
  logic [2*DIM_W-1:0]   prod;

  always_comb begin
    drow     = slot_drow(k);
    dcol     = slot_dcol(k);
    row_x    = {2'b00, r} + {{DIM_W{drow[1]}}, drow};
    col_x    = {2'b00, c} + {{DIM_W{dcol[1]}}, dcol};
    in_range = !row_x[DIM_W+1] && !col_x[DIM_W+1] &&
               (row_x[DIM_W:0] < {1'b0, height}) &&
               (col_x[DIM_W:0] < {1'b0, width});
    prod     = {{DIM_W{1'b0}}, row_x[DIM_W-1:0]} * {{DIM_W{1'b0}}, width};
    ram_addr = base_addr + ADDR_W'(prod) + ADDR_W'(col_x[DIM_W-1:0]);
  end

endmodule

// File: rtl/coeff_window_fetcher.sv
// rtl/coeff_window_fetcher.sv - walks a subband and feeds zero-padded 3x3 windows to the bit-plane coder
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       begin a pass (ignored unless idle)
//   subband_in, base_addr,
//   width, height               pass parameters, latched at start
//   ram_rd, ram_addr, ram_q     coefficient RAM read port (1-cycle read latency)
//   data0..data8, subband       window to the coder, data4 is the centre
//   input_valid, code_ready     window strobe / coder idle
//   busy, done                  pass in progress / end-of-pass pulse
module coeff_window_fetcher
  import coeff_window_fetcher_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DIM_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        subband_in,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] data0,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] data3,
  output logic [DATA_W-1:0] data4,
  output logic [DATA_W-1:0] data5,
  output logic [DATA_W-1:0] data6,
  output logic [DATA_W-1:0] data7,
  output logic [DATA_W-1:0] data8,
  output logic [2:0]        subband,
  output logic              input_valid,
  input  logic              code_ready,
  output logic              busy,
  output logic              done
);

  fetch_state_e      state_q, state_d;
  logic [2:0]        sb_q, sb_d;
  logic [2:0]        sb_out_q, sb_out_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic [DIM_W-1:0]  r_q, r_d;
  logic [DIM_W-1:0]  c_q, c_d;
  logic [3:0]        k_q, k_d;
  logic [DATA_W-1:0] shadow_q [0:8];
  logic [DATA_W-1:0] shadow_d [0:8];
  logic [DATA_W-1:0] data_q [0:8];
  logic [DATA_W-1:0] data_d [0:8];
  logic              shadow_full_q, shadow_full_d;
  logic              coder_free_q, coder_free_d;
  logic              valid_q, valid_d;
  logic              rd_pend_q, rd_pend_d;
  logic [3:0]        rd_slot_q, rd_slot_d;
  logic              last_q, last_d;

  logic              in_range;
  logic [ADDR_W-1:0] gen_addr;
  logic              fire;
  logic              is_last;

  window_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr_gen (
    .r         (r_q),
    .c         (c_q),
    .k         (k_q),
    .width     (width_q),
    .height    (height_q),
    .base_addr (base_q),
    .in_range  (in_range),
    .ram_addr  (gen_addr)
  );

  assign fire    = (state_q == ST_HOLD) && shadow_full_q && coder_free_q && code_ready;
  assign is_last = (r_q == height_q - 1'b1) && (c_q == width_q - 1'b1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: if (k_q == LAST_SLOT) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_HOLD;
      ST_HOLD: begin
        // After the final copy, stay here until the coder frees up again.
        if (fire)                      state_d = is_last ? ST_HOLD : ST_FETCH;
        else if (last_q && coder_free_q) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ram_rd   = 1'b0;
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    if (state_q == ST_FETCH) ram_rd = in_range;
    ram_addr = ram_rd ? gen_addr : '0;
  end

  // Datapath: parameter latch, shadow fill, handshake and scan position
  always_comb begin
    sb_d          = sb_q;
    sb_out_d      = sb_out_q;
    base_d        = base_q;
    width_d       = width_q;
    height_d      = height_q;
    r_d           = r_q;
    c_d           = c_q;
    k_d           = k_q;
    shadow_d      = shadow_q;
    data_d        = data_q;
    shadow_full_d = shadow_full_q;
    coder_free_d  = coder_free_q;
    valid_d       = 1'b0;
    rd_pend_d     = 1'b0;
    rd_slot_d     = rd_slot_q;
    last_d        = last_q;

    // Read issued last cycle lands now.
    if (rd_pend_q) shadow_d[rd_slot_q] = ram_q;
    if (!coder_free_q && code_ready) coder_free_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sb_d          = subband_in;
          base_d        = base_addr;
          width_d       = width;
          height_d      = height;
          r_d           = '0;
          c_d           = '0;
          k_d           = '0;
          last_d        = 1'b0;
          shadow_full_d = 1'b0;
        end
      end
      ST_FETCH: begin
        rd_pend_d = in_range;
        rd_slot_d = k_q;
        if (!in_range) shadow_d[k_q] = '0;
        k_d = (k_q == LAST_SLOT) ? 4'd0 : k_q + 4'd1;
      end
      ST_DRAIN: shadow_full_d = 1'b1;
      ST_HOLD: begin
        if (fire) begin
          valid_d       = 1'b1;
          data_d        = shadow_q;
          sb_out_d      = sb_q;
          shadow_full_d = 1'b0;
          coder_free_d  = 1'b0;
          if (is_last) begin
            last_d = 1'b1;
          end else if (c_q == width_q - 1'b1) begin
            c_d = '0;
            r_d = r_q + 1'b1;
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q          <= '0;
      sb_out_q      <= '0;
      base_q        <= '0;
      width_q       <= '0;
      height_q      <= '0;
      r_q           <= '0;
      c_q           <= '0;
      k_q           <= '0;
      shadow_full_q <= 1'b0;
      coder_free_q  <= 1'b1;
      valid_q       <= 1'b0;
      rd_pend_q     <= 1'b0;
      rd_slot_q     <= '0;
      last_q        <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        shadow_q[i] <= '0;
        data_q[i]   <= '0;
      end
    end else begin
      sb_q          <= sb_d;
      sb_out_q      <= sb_out_d;
      base_q        <= base_d;
      width_q       <= width_d;
      height_q      <= height_d;
      r_q           <= r_d;
      c_q           <= c_d;
      k_q           <= k_d;
      shadow_full_q <= shadow_full_d;
      coder_free_q  <= coder_free_d;
      valid_q       <= valid_d;
      rd_pend_q     <= rd_pend_d;
      rd_slot_q     <= rd_slot_d;
      last_q        <= last_d;
      for (int i = 0; i < 9; i++) begin
        shadow_q[i] <= shadow_d[i];
        data_q[i]   <= data_d[i];
      end
    end
  end

  assign data0       = data_q[0];
  assign data1       = data_q[1];
  assign data2       = data_q[2];
  assign data3       = data_q[3];
  assign data4       = data_q[4];
  assign data5       = data_q[5];
  assign data6       = data_q[6];
  assign data7       = data_q[7];
  assign data8       = data_q[8];
  assign subband     = sb_out_q;
  assign input_valid = valid_q;

endmodule

// File: tb/tb_coeff_window_fetcher.sv
// tb/tb_coeff_window_fetcher.sv - scoreboard bench for coeff_window_fetcher
module tb_coeff_window_fetcher;
  import coeff_window_fetcher_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DIM_W  = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        subband_in = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [DIM_W-1:0]  width = '0;
  logic [DIM_W-1:0]  height = '0;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q = '0;
  logic [DATA_W-1:0] data0, data1, data2, data3, data4, data5, data6, data7, data8;
  logic [2:0]        subband;
  logic              input_valid;
  logic              code_ready = 1'b1;
  logic              busy;
  logic              done;

  coeff_window_fetcher #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DIM_W  (DIM_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .subband_in  (subband_in),
    .base_addr   (base_addr),
    .width       (width),
    .height      (height),
    .ram_rd      (ram_rd),
    .ram_addr    (ram_addr),
    .ram_q       (ram_q),
    .data0       (data0),
    .data1       (data1),
    .data2       (data2),
    .data3       (data3),
    .data4       (data4),
    .data5       (data5),
    .data6       (data6),
    .data7       (data7),
    .data8       (data8),
    .subband     (subband),
    .input_valid (input_valid),
    .code_ready  (code_ready),
    .busy        (busy),
    .done        (done)
  );

  typedef struct packed {
    logic [2:0]   sb;
    logic [143:0] d;
  } win_t;

  win_t        exp_win_q[$];
  logic [15:0] exp_rd_q[$];
  win_t        w_pop;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_valid = 0;
  int   done_cnt = 0;
  int   last_valid_cyc = -1;
  int   hold_cnt = 0;
  bit   slow = 1'b0;
  bit   stable_bad = 1'b0;
  bit   have_last = 1'b0;
  logic [146:0] last_vec = '0;

  wire [146:0] obs_vec = {subband, data8, data7, data6, data5, data4, data3, data2, data1, data0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: RAM[a] = a, one-cycle latency, garbage when not read.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ram_q <= '0;
    else        ram_q <= ram_rd ? ram_addr : 16'hDEAD;
  end

  // Coder model: in slow mode, code_ready stays low for 6 cycles after each window.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_ready <= 1'b1;
      hold_cnt   <= 0;
    end else if (input_valid && slow) begin
      code_ready <= 1'b0;
      hold_cnt   <= 6;
    end else if (hold_cnt > 0) begin
      if (hold_cnt == 1) code_ready <= 1'b1;
      hold_cnt <= hold_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor / scoreboard pop side
  always @(negedge clk) begin
    if (!rst_n) begin
      have_last      = 1'b0;
      stable_bad     = 1'b0;
      last_valid_cyc = -1;
    end else begin
      if (ram_rd) begin
        check("rd_expected", exp_rd_q.size() != 0, 1);
        if (exp_rd_q.size() != 0) check("rd_addr", ram_addr, exp_rd_q.pop_front());
      end
      if (input_valid) begin
        n_valid++;
        check("win_expected", exp_win_q.size() != 0, 1);
        if (exp_win_q.size() != 0) begin
          w_pop = exp_win_q.pop_front();
          check("window", obs_vec, {w_pop.sb, w_pop.d});
        end
        if (have_last) check("data_stable", stable_bad, 0);
        if (last_valid_cyc >= 0)
          check("valid_spacing", ((cyc - last_valid_cyc) >= (slow ? 7 : 2)) &&
                                 ((cyc - last_valid_cyc) <= 11), 1);
        last_valid_cyc = cyc;
        last_vec       = obs_vec;
        have_last      = 1'b1;
        stable_bad     = 1'b0;
      end else if (have_last && obs_vec !== last_vec) begin
        stable_bad = 1'b1;
      end
      if (done) begin
        done_cnt++;
        check("done_after_all", exp_win_q.size(), 0);
      end
    end
  end

  task automatic push_pass(input logic [2:0] sb, input logic [15:0] base, input int w, input int h);
    win_t        x;
    int          rr, cc;
    logic [15:0] a;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        x.sb = sb;
        x.d  = '0;
        for (int k = 0; k < 9; k++) begin
          rr = r + k / 3 - 1;
          cc = c + k % 3 - 1;
          if (rr >= 0 && rr < h && cc >= 0 && cc < w) begin
            a = 16'(int'(base) + rr * w + cc);
            x.d[k*16 +: 16] = a;
            exp_rd_q.push_back(a);
          end
        end
        exp_win_q.push_back(x);
      end
    end
  endtask

  task automatic prep();
    n_valid        = 0;
    done_cnt       = 0;
    last_valid_cyc = -1;
    have_last      = 1'b0;
    stable_bad     = 1'b0;
  endtask

  task automatic start_pass(input logic [2:0] sb, input logic [15:0] base, input int w, input int h);
    @(negedge clk);
    subband_in = sb;
    base_addr  = base;
    width      = 9'(w);
    height     = 9'(h);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_valid(input int n);
    for (int i = 0; i < 1000 && n_valid < n; i++) begin
      @(negedge clk);
      #1;
    end
    check("valid_timeout", n_valid >= n, 1);
  endtask

  task automatic finish_pass(input int exp_n);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("done_seen", done_cnt, 1);
    repeat (4) @(negedge clk);
    #1;
    check("done_once", done_cnt, 1);
    check("valid_count", n_valid, exp_n);
    check("win_q_empty", exp_win_q.size(), 0);
    check("rd_q_empty", exp_rd_q.size(), 0);
    check("busy_idle", busy, 0);
  endtask

  task automatic check_cleared();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", input_valid, 0);
    check("rst_ram_rd", ram_rd, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_data", obs_vec, 0);
  endtask

  initial begin
    // Reset state
    #12;
    check_cleared();
    @(negedge clk);
    rst_n = 1'b1;

    // 4x4 at 0x0100, coder always ready
    prep();
    push_pass(SB_LL, 16'h0100, 4, 4);
    start_pass(SB_LL, 16'h0100, 4, 4);
    finish_pass(16);

    // 1x1 at 0x0200: single read, all neighbours padded
    prep();
    push_pass(SB_HH2, 16'h0200, 1, 1);
    start_pass(SB_HH2, 16'h0200, 1, 1);
    finish_pass(1);

    // Slow coder: code_ready low 6 cycles after each window
    prep();
    slow = 1'b1;
    push_pass(SB_HH1, 16'h0400, 3, 3);
    start_pass(SB_HH1, 16'h0400, 3, 3);
    finish_pass(9);
    slow = 1'b0;

    // 3 rows x 5 columns, includes centre (1,2)
    prep();
    push_pass(SB_HL2, 16'h0040, 5, 3);
    start_pass(SB_HL2, 16'h0040, 5, 3);
    finish_pass(15);

    // Reset during FETCH of window (1,1), then a full re-run
    prep();
    push_pass(SB_LH1, 16'h0100, 4, 4);
    start_pass(SB_LH1, 16'h0100, 4, 4);
    wait_valid(5);
    repeat (3) @(negedge clk);
    #1;
    check("mid_busy", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_cleared();
    exp_win_q.delete();
    exp_rd_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prep();
    push_pass(SB_LH1, 16'h0100, 4, 4);
    start_pass(SB_LH1, 16'h0100, 4, 4);
    finish_pass(16);

    // start while busy is ignored
    prep();
    push_pass(SB_HL1, 16'h0500, 6, 2);
    start_pass(SB_HL1, 16'h0500, 6, 2);
    wait_valid(2);
    start_pass(SB_HH2, 16'h0900, 3, 3);
    finish_pass(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
